// File: rtl/countdown_pkg.sv
// ============================================================================
//  Module      : countdown_pkg
//  Description : Shared state type and default width for the countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : countdown_pkg

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with a registered terminal-count pulse.
//                Define COUNTDOWN_AUTORELOAD_EN for periodic reload on
//                terminal count; otherwise the timer is one-shot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    input  logic             stop,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Priority: load > stop > count_en; tc is a single-cycle pulse by default.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else if (stop) begin
            state_d  = IDLE;
        end else if ((state_q == RUN) && count_en) begin
            if (count_q == C_ONE) begin
                tc_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = IDLE;
`endif
            end else begin
                count_d = count_q - C_ONE;
            end
        end
    end

    assign o_count = count_q;
    assign o_busy  = (state_q == RUN);
    assign o_tc    = tc_q;

    // While running, the count is never zero and never exceeds the reload value.
    a_run_range : assert property (@(posedge clk) disable iff (!resetn)
        (state_q == RUN) |-> ((count_q != '0) && (count_q <= reload_q)));

endmodule : countdown_timer

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Vector table, corner sequences and random run against a
//                behavioural model of the countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             count_en;
    logic             stop;
    logic [WIDTH-1:0] o_count;
    logic             o_busy;
    logic             o_tc;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .load_value (load_value),
        .count_en   (count_en),
        .stop       (stop),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_tc       (o_tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       ld;
        logic [7:0] lv;
        logic       ce;
        logic       st;
        int         exp_count;
        logic       exp_busy;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic ld, input logic [7:0] lv,
                         input logic ce, input logic st);
        resetn = rn; load = ld; load_value = lv; count_en = ce; stop = st;
    endtask

    task automatic step_check(input string tag, input int c, input logic b, input logic t);
        @(posedge clk);
        #1;
        check({tag, ".count"}, int'(o_count), c);
        check({tag, ".busy"},  int'(o_busy),  int'(b));
        check({tag, ".tc"},    int'(o_tc),    int'(t));
    endtask

    // Reference model state: plain integers following the behavioural rules.
    int  m_count;
    int  m_reload;
    bit  m_run;
    bit  m_tc;

    task automatic model_step(input logic rn, input logic ld, input int lv,
                              input logic ce, input logic st);
        m_tc = 1'b0;
        if (!rn) begin
            m_count = 0; m_reload = 0; m_run = 1'b0;
        end else if (ld) begin
            m_count = lv; m_reload = lv; m_run = (lv != 0);
        end else if (st) begin
            m_run = 1'b0;
        end else if (m_run && ce) begin
            if (m_count == 1) begin
                m_tc = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                m_count = m_reload;
`else
                m_count = 0;
                m_run   = 1'b0;
`endif
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'd5,  1'b0, 1'b0, 5, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 4, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 3, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 3, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 3, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 8'd7,  1'b0, 1'b0, 7, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 6, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'd9,  1'b1, 1'b1, 9, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'd0,  1'b1, 1'b1, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'd2,  1'b1, 1'b0, 2, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 2, 1'b0, 1'b0};

        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rn, vecs[i].ld, vecs[i].lv, vecs[i].ce, vecs[i].st);
            step_check($sformatf("vec%0d", i), vecs[i].exp_count,
                       vecs[i].exp_busy, vecs[i].exp_tc);
        end

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Periodic: load 4 then 12 enabled edges -> 3,2,1,4(tc),...
        drive(1'b1, 1'b1, 8'd4, 1'b0, 1'b0);
        step_check("ar.load", 4, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step_check($sformatf("ar.k%0d", k), 4 - (k % 4), 1'b1, (k % 4) == 0);
        end
        // Reload value 1 ticks on every enabled edge.
        drive(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        step_check("ar1.load", 1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step_check($sformatf("ar1.k%0d", k), 1, 1'b1, 1'b1);
        end
`else
        // One-shot: load 3 -> 2,1,0 with tc and busy falling on the 0 cycle.
        drive(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        step_check("os.load", 3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        step_check("os.k1", 2, 1'b1, 1'b0);
        step_check("os.k2", 1, 1'b1, 1'b0);
        step_check("os.k3", 0, 1'b0, 1'b1);
        step_check("os.k4", 0, 1'b0, 1'b0);
        step_check("os.k5", 0, 1'b0, 1'b0);
`endif
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
        step_check("stop.clear", -1 == -1 ? int'(o_count) : 0, 1'b0, 1'b0);

        // Reset mid-run: load 200, 50 enabled edges, then one reset cycle.
        drive(1'b1, 1'b1, 8'd200, 1'b0, 1'b0);
        step_check("rst.load", 200, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) @(posedge clk);
        #1;
        check("rst.run50", int'(o_count), 150);
        drive(1'b0, 1'b1, 8'd9, 1'b1, 1'b1);
        step_check("rst.apply", 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        step_check("rst.after", 0, 1'b0, 1'b0);

        // Random run against the model.
        model_step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 3000; n++) begin
            logic       rn, ld, ce, st;
            logic [7:0] lv;
            rn = ($urandom_range(0, 99) >= 2);
            ld = ($urandom_range(0, 99) < 8);
            st = ($urandom_range(0, 99) < 4);
            ce = ($urandom_range(0, 99) < 75);
            lv = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            drive(rn, ld, lv, ce, st);
            model_step(rn, ld, int'(lv), ce, st);
            @(posedge clk);
            #1;
            if ((int'(o_count) != m_count) || (o_busy != m_run) || (o_tc != m_tc)) begin
                errors++;
                $display("FAIL rnd%0d: got count=%0d busy=%0b tc=%0b expected count=%0d busy=%0b tc=%0b",
                         n, o_count, o_busy, o_tc, m_count, m_run, m_tc);
            end
            checks++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_countdown_timer

`default_nettype wire
